// File: rtl/tt_warriorjacq9_pkg.sv
// Shared types and constants for the tt_um_warriorjacq9 4-bit ALU core:
// FSM state encoding, opcode values and bus-request codes.
package tt_warriorjacq9_pkg;

    // State encoding is exposed directly on uo_out[7:6].
    typedef enum logic [1:0] {
        ST_FETCH  = 2'b00,
        ST_OPREQ  = 2'b01,
        ST_REGREQ = 2'b10,
        ST_EXEC   = 2'b11
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_SUBI = 4'b0010;
    localparam logic [3:0] OP_LDR  = 4'b0011;
    localparam logic [3:0] OP_ANDI = 4'b0100;
    localparam logic [3:0] OP_ORI  = 4'b0101;
    localparam logic [3:0] OP_XORI = 4'b0110;

    localparam logic [3:0] BUSREQ_IDLE    = 4'b0000;
    localparam logic [3:0] BUSREQ_REGVAL  = 4'b0001;
    localparam logic [3:0] BUSREQ_OPERAND = 4'b0011;

    // Moore decode of the bus-request code from the current state.
    function automatic logic [3:0] busreq_of(input state_t st);
        case (st)
            ST_OPREQ:  busreq_of = BUSREQ_OPERAND;
            ST_REGREQ: busreq_of = BUSREQ_REGVAL;
            default:   busreq_of = BUSREQ_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/warriorjacq9_alu.sv
// Combinational ALU plus opcode-validity decoder.
// Optional feature macro: ALU_LOGIC_EN enables ANDI/ORI/XORI (0100..0110);
// without it those opcodes decode as NOPs.
module warriorjacq9_alu
    import tt_warriorjacq9_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [3:0] rval,
    input  logic [3:0] imm,
    output logic [3:0] result,
    output logic       carry,
    input  logic [3:0] fetch_op,
    output logic       fetch_valid
);

    logic [4:0] sum;
    logic [4:0] diff;

    assign sum  = {1'b0, rval} + {1'b0, imm};
    assign diff = {1'b0, rval} - {1'b0, imm};

    // Result/carry for the latched opcode; diff[4] is the borrow (rval < imm).
    always_comb begin
        result = 4'h0;
        carry  = 1'b0;
        case (opcode)
            OP_ADDI: begin
                result = sum[3:0];
                carry  = sum[4];
            end
            OP_SUBI: begin
                result = diff[3:0];
                carry  = diff[4];
            end
            OP_LDR:  result = rval;
`ifdef ALU_LOGIC_EN
            OP_ANDI: result = rval & imm;
            OP_ORI:  result = rval | imm;
            OP_XORI: result = rval ^ imm;
`endif
            default: ;
        endcase
    end

    // Decides whether the opcode currently on the fetch bus starts an operation.
    always_comb begin
        fetch_valid = 1'b0;
        case (fetch_op)
            OP_ADDI, OP_SUBI, OP_LDR: fetch_valid = 1'b1;
`ifdef ALU_LOGIC_EN
            OP_ANDI, OP_ORI, OP_XORI: fetch_valid = 1'b1;
`endif
            default: fetch_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/tt_um_warriorjacq9.sv
// TinyTapeout top: 4-state fetch/operand/register/execute FSM around a
// 4-bit ALU. Optional feature macro ALU_LOGIC_EN (handled in the ALU).
module tt_um_warriorjacq9
    import tt_warriorjacq9_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_t     state_reg, state_next;
    logic [3:0] opcode_reg;
    logic [3:0] imm_reg;
    logic [3:0] rsel_reg;
    logic [3:0] rval_reg;
    logic [3:0] result_reg;
    logic       carry_reg;
    logic       zero_reg;

    logic [3:0] alu_result;
    logic       alu_carry;
    logic       fetch_valid;

    warriorjacq9_alu u_alu (
        .opcode      (opcode_reg),
        .rval        (rval_reg),
        .imm         (imm_reg),
        .result      (alu_result),
        .carry       (alu_carry),
        .fetch_op    (ui_in[3:0]),
        .fetch_valid (fetch_valid)
    );

    // Next-state logic; NOP/unused opcodes keep the FSM parked in FETCH.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_FETCH:  state_next = fetch_valid ? ST_OPREQ : ST_FETCH;
            ST_OPREQ:  state_next = ST_REGREQ;
            ST_REGREQ: state_next = ST_EXEC;
            ST_EXEC:   state_next = ST_FETCH;
            default:   state_next = ST_FETCH;
        endcase
    end

    // State and latches; everything freezes while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_FETCH;
            opcode_reg <= 4'h0;
            imm_reg    <= 4'h0;
            rsel_reg   <= 4'h0;
            rval_reg   <= 4'h0;
            result_reg <= 4'h0;
            carry_reg  <= 1'b0;
            zero_reg   <= 1'b0;
        end else if (ena) begin
            state_reg <= state_next;
            case (state_reg)
                ST_FETCH: begin
                    opcode_reg <= ui_in[3:0];
                    imm_reg    <= ui_in[7:4];
                end
                ST_OPREQ:  rsel_reg <= ui_in[7:4];
                ST_REGREQ: rval_reg <= uio_in[3:0];
                ST_EXEC: begin
                    result_reg <= alu_result;
                    carry_reg  <= alu_carry;
                    zero_reg   <= (alu_result == 4'h0);
                end
                default: ;
            endcase
        end
    end

    // Outputs are pure decodes of registered state.
    always_comb begin
        uo_out  = {state_reg, zero_reg, carry_reg, busreq_of(state_reg)};
        uio_out = {4'h0, result_reg};
        uio_oe  = (state_reg == ST_REGREQ) ? 8'h00 : 8'h0F;
    end

    // rsel is a debug-only latch and uio_in[7:4] is ignored by design.
    logic unused_ok;
    assign unused_ok = &{1'b0, rsel_reg, uio_in[7:4]};

endmodule

// File: tb/tb_tt_um_warriorjacq9.sv
// Directed-vector bench for tt_um_warriorjacq9. Inputs are driven and outputs
// sampled on the falling edge; the bench plays the external register block.
module tb_tt_um_warriorjacq9;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_cmp = 0;
    int n_err = 0;

    tt_um_warriorjacq9 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end else begin
            $display("ok   %s: %02h", tag, got);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One complete instruction: drives fetch, answers OPREQ and REGREQ,
    // checks the bus-request sequence and the final result/flags.
    task automatic run_op(input string name, input logic [3:0] op, input logic [3:0] imm,
                          input logic [3:0] rsel, input logic [3:0] rval,
                          input logic [3:0] exp_res, input logic exp_c, input logic exp_z);
        check({name, " fetch busreq"}, uo_out & 8'hCF, 8'h00);
        ui_in = {imm, op};
        next_cycle();
        check({name, " opreq"}, uo_out & 8'hCF, 8'h43);
        ui_in = {rsel, op};
        next_cycle();
        check({name, " regreq"}, uo_out & 8'hCF, 8'h81);
        check({name, " regreq oe"}, uio_oe, 8'h00);
        uio_in = {4'h0, rval};
        next_cycle();
        check({name, " exec"}, uo_out & 8'hCF, 8'hC0);
        check({name, " exec oe"}, uio_oe, 8'h0F);
        ui_in  = 8'h00;
        uio_in = 8'h00;
        next_cycle();
        check({name, " result"}, uio_out, {4'h0, exp_res});
        check({name, " flags"}, uo_out, {2'b00, exp_z, exp_c, 4'b0000});
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #12;
        check("rst uo_out", uo_out, 8'h00);
        check("rst uio_out", uio_out, 8'h00);
        check("rst uio_oe", uio_oe, 8'h0F);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) next_cycle();
        check("idle uo_out", uo_out, 8'h00);
        check("idle uio_out", uio_out, 8'h00);

        //       name         op     imm   rsel  rval  res   c     z
        run_op("ADDI 3+4",   4'h1, 4'h3, 4'h1, 4'h4, 4'h7, 1'b0, 1'b0);
        run_op("ADDI wrap",  4'h1, 4'h9, 4'h2, 4'h8, 4'h1, 1'b1, 1'b0);
        run_op("SUBI 3-5",   4'h2, 4'h5, 4'h3, 4'h3, 4'hE, 1'b1, 1'b0);
        run_op("SUBI 4-4",   4'h2, 4'h4, 4'h4, 4'h4, 4'h0, 1'b0, 1'b1);
        run_op("LDR A",      4'h3, 4'h0, 4'h5, 4'hA, 4'hA, 1'b0, 1'b0);

        // ena low in OPREQ freezes state and bus request.
        ui_in = 8'h21;
        next_cycle();
        check("ena opreq", uo_out, 8'h43);
        ena = 1'b0;
        ui_in = 8'h61;
        for (int i = 0; i < 5; i++) next_cycle();
        check("ena frozen", uo_out, 8'h43);
        check("ena frozen res", uio_out, 8'h0A);
        ena = 1'b1;
        next_cycle();
        check("ena resume", uo_out & 8'hCF, 8'h81);
        uio_in = 8'h01;
        next_cycle();
        ui_in = 8'h00;
        next_cycle();
        check("ena result", uio_out, 8'h03);   // imm 2 + rval 1

        // Reset pulse in REGREQ returns to reset values immediately.
        ui_in = 8'h73;
        next_cycle();
        next_cycle();
        check("pre-rst regreq", uo_out & 8'hCF, 8'h81);
        #1 rst_n = 1'b0;
        #1;
        check("midrst uo_out", uo_out, 8'h00);
        check("midrst uio_out", uio_out, 8'h00);
        check("midrst uio_oe", uio_oe, 8'h0F);
        ui_in = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        check("post-rst state", uo_out, 8'h00);

        // Preload a nonzero result, then try opcode 0110.
        run_op("LDR 9",      4'h3, 4'h0, 4'h1, 4'h9, 4'h9, 1'b0, 1'b0);
`ifdef ALU_LOGIC_EN
        run_op("XORI F^5",   4'h6, 4'hF, 4'h1, 4'h5, 4'hA, 1'b0, 1'b0);
`else
        ui_in = 8'hF6;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            check("op6 nop state", uo_out, 8'h00);
        end
        check("op6 nop result", uio_out, 8'h09);
        ui_in = 8'h00;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
